// File: rtl/matrix_rowop_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the matrix row-operation controller.
package matrix_pkg;

  localparam int ELEM_W  = 8;
  localparam int LANES   = 5;
  localparam int ROW_W   = ELEM_W * LANES;
  localparam int MAX_DIM = 5;
  localparam int ADDR_W  = 3;

  localparam logic [ADDR_W-1:0] MAX_DIM_A = ADDR_W'(MAX_DIM);

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_EX   = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // A dimension is usable only if it names at least one row and fits the memories.
  function automatic logic dim_valid(input logic [ADDR_W-1:0] d);
    return (d != 3'd0) && (d <= MAX_DIM_A);
  endfunction

endpackage

// File: rtl/matrix_rowop_ctrl_if.sv
// Command, row-memory and ALU signals of the row-operation controller.
interface matrix_rowop_ctrl_if;
  import matrix_pkg::*;

  logic              start;
  logic              op_sel;
  logic [ADDR_W-1:0] dim;
  logic              busy;
  logic              done;
  logic              err;
  logic              ovf;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ROW_W-1:0]  rd_data_a;
  logic [ROW_W-1:0]  rd_data_b;
  logic              alu_op;
  logic [ROW_W-1:0]  alu_m1;
  logic [ROW_W-1:0]  alu_m2;
  logic [ROW_W-1:0]  alu_out;
  logic              alu_ovf;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ROW_W-1:0]  wr_data;

  modport master (
    input  start, op_sel, dim, rd_data_a, rd_data_b, alu_out, alu_ovf,
    output busy, done, err, ovf, rd_en, rd_addr, alu_op, alu_m1, alu_m2,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, op_sel, dim, rd_data_a, rd_data_b, alu_out, alu_ovf,
    input  busy, done, err, ovf, rd_en, rd_addr, alu_op, alu_m1, alu_m2,
           wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/matrix_rowop_ctrl.sv
// Row-by-row read/execute/write sequencer for a shared 5-lane row ALU.
// Optional MATRIX_ROWOP_OVF_ABORT_EN: stop after the first row that overflows.
module matrix_rowop_ctrl
  import matrix_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  matrix_rowop_ctrl_if.master bus
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ADDR_W-1:0] row_r;
  logic [ADDR_W-1:0] row_nxt_s;
  logic [ADDR_W-1:0] dim_r;
  logic              accept_s;
  logic              last_row_s;
  logic              abort_s;

  assign accept_s   = (state_r == ST_IDLE) && bus.start;
  assign last_row_s = (row_r == (dim_r - 3'd1));

`ifdef MATRIX_ROWOP_OVF_ABORT_EN
  assign abort_s = bus.alu_ovf;
`else
  assign abort_s = 1'b0;
`endif

  // The result row goes straight from the ALU to memory during WB.
  assign bus.wr_data = bus.alu_out;

  // Next-state and row-counter selection.
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          row_nxt_s   = '0;
          state_nxt_s = dim_valid(bus.dim) ? ST_RD : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD:   state_nxt_s = ST_EX;
      ST_EX:   state_nxt_s = ST_WB;
      ST_WB: begin
        if (last_row_s || abort_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          row_nxt_s   = row_r + 3'd1;
          state_nxt_s = ST_RD;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: begin
        state_nxt_s = ST_IDLE;
        row_nxt_s   = '0;
      end
    endcase
  end

  // State, operands, status and strobes; strobes are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      row_r       <= '0;
      dim_r       <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      bus.ovf     <= 1'b0;
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.alu_op  <= 1'b0;
      bus.alu_m1  <= '0;
      bus.alu_m2  <= '0;
    end else begin
      state_r     <= state_nxt_s;
      row_r       <= row_nxt_s;
      bus.busy    <= (state_nxt_s == ST_RD) || (state_nxt_s == ST_EX) ||
                     (state_nxt_s == ST_WB);
      bus.done    <= (state_nxt_s == ST_DONE);
      bus.rd_en   <= (state_nxt_s == ST_RD);
      bus.rd_addr <= row_nxt_s;
      bus.wr_en   <= (state_nxt_s == ST_WB);
      bus.wr_addr <= row_nxt_s;

      if (accept_s) begin
        bus.alu_op <= bus.op_sel;
        dim_r      <= bus.dim;
        bus.ovf    <= 1'b0;
        bus.err    <= !dim_valid(bus.dim);
      end else if (state_r == ST_WB) begin
        bus.ovf    <= bus.ovf | bus.alu_ovf;
      end else begin
        bus.ovf    <= bus.ovf;
      end

      if (state_r == ST_EX) begin
        bus.alu_m1 <= bus.rd_data_a;
        bus.alu_m2 <= bus.rd_data_b;
      end else begin
        bus.alu_m1 <= bus.alu_m1;
        bus.alu_m2 <= bus.alu_m2;
      end
    end
  end

endmodule

// File: tb/tb_matrix_rowop_ctrl.sv
// Scoreboard bench for matrix_rowop_ctrl with behavioural row memories and row ALU.
module tb_matrix_rowop_ctrl;
  import matrix_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ROW_W-1:0]  data;
  } wr_t;

  typedef struct {
    int   cyc;
    logic err;
    logic ovf;
  } dn_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   passed;
  int   rd_cnt;

  logic [ROW_W-1:0] mem_a [0:7];
  logic [ROW_W-1:0] mem_b [0:7];

  wr_t wq[$];
  dn_t dq[$];

  matrix_rowop_ctrl_if bus();

  matrix_rowop_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous row memories: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data_a <= mem_a[bus.rd_addr];
      bus.rd_data_b <= mem_b[bus.rd_addr];
    end
  end

  function automatic logic [ROW_W:0] alu_f(input logic [ROW_W-1:0] a,
                                           input logic [ROW_W-1:0] b,
                                           input logic op);
    logic [ROW_W-1:0] r;
    logic             ov;
    logic [7:0]       x;
    logic [7:0]       y;
    logic [7:0]       s;
    r  = '0;
    ov = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      x = a[8*i +: 8];
      y = b[8*i +: 8];
      if (op == OP_SUB) begin
        s  = x - y;
        ov = ov | ((x[7] != y[7]) && (s[7] != x[7]));
      end else begin
        s  = x + y;
        ov = ov | ((x[7] == y[7]) && (s[7] != x[7]));
      end
      r[8*i +: 8] = s;
    end
    return {ov, r};
  endfunction

  assign {bus.alu_ovf, bus.alu_out} = alu_f(bus.alu_m1, bus.alu_m2, bus.alu_op);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pop and compare whenever the DUT writes a row or pulses done.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_en) rd_cnt++;
      if (bus.rd_en && bus.wr_en) chk("rd_wr_overlap", 64'd1, 64'd0);
      if (bus.wr_en) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", {61'd0, bus.wr_addr}, 64'hFFFF);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", {61'd0, bus.wr_addr}, {61'd0, w.addr});
          chk("wr_data", {24'd0, bus.wr_data}, {24'd0, w.data});
        end
      end
      if (bus.done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 64'(cyc), 64'hFFFF);
        end else begin
          dn_t d;
          d = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
          chk("done_err", {63'd0, bus.err}, {63'd0, d.err});
          chk("done_ovf", {63'd0, bus.ovf}, {63'd0, d.ovf});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [ROW_W-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  // Issues a one-cycle start; returns in the cycle after the accept edge.
  task automatic run_op(input logic [2:0] d, input logic op, input int lat,
                        input logic e, input logic o, input logic push_done,
                        output int sc);
    dn_t x;
    bus.start  = 1'b1;
    bus.dim    = d;
    bus.op_sel = op;
    sc = cyc;
    if (push_done) begin
      x.cyc = sc + lat;
      x.err = e;
      x.ovf = o;
      dq.push_back(x);
    end
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300; i++) begin
      if (wq.size() == 0 && dq.size() == 0 && !bus.busy && !bus.done) break;
      step(1);
    end
    chk("drain_timeout", 64'(wq.size() + dq.size()), 64'd0);
    step(3);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ctrl"}, {57'd0, bus.busy, bus.done, bus.err, bus.ovf, bus.rd_en,
                          bus.wr_en, bus.alu_op}, 64'd0);
    chk({name, "_addr"}, {58'd0, bus.rd_addr, bus.wr_addr}, 64'd0);
    chk({name, "_m1"}, {24'd0, bus.alu_m1}, 64'd0);
    chk({name, "_m2"}, {24'd0, bus.alu_m2}, 64'd0);
  endtask

  task automatic load_uniform(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = a;
      mem_b[i] = b;
    end
  endtask

  initial begin
    int sc;
    int s2;
    int lat1;
    int r0;
    cyc        = 0;
    total      = 0;
    passed     = 0;
    rd_cnt     = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op_sel = 1'b0;
    bus.dim    = 3'd0;
    load_uniform(40'h0, 40'h0);

    step(3);
    chk_reset_outputs("reset");
    rst = 1'b0;
    step(2);

    // Invalid dimensions: immediate done with err, no memory traffic; err holds.
    r0 = rd_cnt;
    run_op(3'd0, OP_ADD, 1, 1'b1, 1'b0, 1'b1, sc);
    drain();
    chk("dim0_no_reads", 64'(rd_cnt - r0), 64'd0);
    chk("dim0_err_held", {63'd0, bus.err}, 64'd1);
    r0 = rd_cnt;
    run_op(3'd6, OP_SUB, 1, 1'b1, 1'b0, 1'b1, sc);
    drain();
    chk("dim6_no_reads", 64'(rd_cnt - r0), 64'd0);
    chk("dim6_err_held", {63'd0, bus.err}, 64'd1);

    // dim=5 subtract 0x0A - 0x03 per byte; clears err from the previous op.
    load_uniform(40'h0A0A0A0A0A, 40'h0303030303);
    for (int i = 0; i < 5; i++) push_wr(3'(i), 40'h0707070707);
    r0 = rd_cnt;
    run_op(3'd5, OP_SUB, 16, 1'b0, 1'b0, 1'b1, sc);
    drain();
    chk("dim5_reads", 64'(rd_cnt - r0), 64'd5);

    // dim=3 add with 0x7F + 0x01 in row 1 lane 0.
    load_uniform(40'h0, 40'h0);
    mem_a[1] = 40'h000000007F;
    mem_b[1] = 40'h0000000001;
    push_wr(3'd0, 40'h0);
    push_wr(3'd1, 40'h0000000080);
`ifdef MATRIX_ROWOP_OVF_ABORT_EN
    run_op(3'd3, OP_ADD, 7, 1'b0, 1'b1, 1'b1, sc);
`else
    push_wr(3'd2, 40'h0);
    run_op(3'd3, OP_ADD, 10, 1'b0, 1'b1, 1'b1, sc);
`endif
    drain();
    chk("ovf_held", {63'd0, bus.ovf}, 64'd1);

    // Start re-pulsed while busy must be ignored.
    load_uniform(40'h0A0A0A0A0A, 40'h0303030303);
    for (int i = 0; i < 5; i++) push_wr(3'(i), 40'h0D0D0D0D0D);
    run_op(3'd5, OP_ADD, 16, 1'b0, 1'b0, 1'b1, sc);
    step(4);
    bus.start  = 1'b1;
    bus.dim    = 3'd2;
    bus.op_sel = OP_SUB;
    step(1);
    bus.start  = 1'b0;
    drain();
    step(20);

    // Reset during cycle 7 of a dim=5 op: rows 0 and 1 written, nothing after.
    push_wr(3'd0, 40'h0707070707);
    push_wr(3'd1, 40'h0707070707);
    run_op(3'd5, OP_SUB, 16, 1'b0, 1'b0, 1'b0, sc);
    step(6);
    rst = 1'b1;
    step(1);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    step(25);
    chk("midrst_writes_left", 64'(wq.size()), 64'd0);
    for (int i = 0; i < 5; i++) push_wr(3'(i), 40'h0707070707);
    run_op(3'd5, OP_SUB, 16, 1'b0, 1'b0, 1'b1, sc);
    drain();

    // start held high, dim=2: add (overflows) then sub (clean), back to back.
    load_uniform(40'h0, 40'h0);
    mem_a[0] = 40'h000000007F;
    mem_b[0] = 40'h0000000001;
    push_wr(3'd0, 40'h0000000080);
`ifdef MATRIX_ROWOP_OVF_ABORT_EN
    lat1 = 4;
`else
    lat1 = 7;
    push_wr(3'd1, 40'h0);
`endif
    push_wr(3'd0, 40'h000000007E);
    push_wr(3'd1, 40'h0);
    bus.start  = 1'b1;
    bus.dim    = 3'd2;
    bus.op_sel = OP_ADD;
    sc = cyc;
    s2 = sc + lat1 + 1;
    dq.push_back('{cyc: sc + lat1, err: 1'b0, ovf: 1'b1});
    dq.push_back('{cyc: s2 + 7, err: 1'b0, ovf: 1'b0});
    step(1);
    bus.op_sel = OP_SUB;
    step(s2 - sc - 1);
    chk("b2b_idle_busy", {63'd0, bus.busy}, 64'd0);
    step(1);
    chk("b2b_rd_after_idle", {63'd0, bus.rd_en}, 64'd1);
    bus.start = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
